// File: rtl/sat_pkg.sv
// Shared encodings for the CNF streamer: accelerator command codes, FSM states
// and the layout of one buffered literal.
package sat_pkg;

  localparam int VAR_W_DEF = 5;

  localparam logic [1:0] CMD_RESET  = 2'b00;
  localparam logic [1:0] CMD_LIT    = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_HOLD   = 2'b11;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_RST    = 3'd1,
    ST_LIT    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_WAIT   = 3'd4,
    ST_REPORT = 3'd5
  } state_t;

  // Buffer entries are packed {eoc, neg, vidx}, most significant first.
  typedef struct packed {
    logic                 eoc;
    logic                 neg;
    logic [VAR_W_DEF-1:0] vidx;
  } lit_t;

endpackage

// File: rtl/sat_lit_buffer.sv
// Literal store for the CNF streamer: register array written at the fill
// count, read combinationally at the replay pointer, plus sticky overflow.
module sat_lit_buffer
  import sat_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int VAR_W = VAR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [VAR_W+1:0] i_wr_data,
  input  logic             i_clear,
  input  logic             i_ovf_set,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output logic [VAR_W+1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next,
  output logic             o_ovf
);

  logic [VAR_W+1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [CNT_W-1:0] w_count_next;

  // Writes only happen below DEPTH, so the low bits of the count are the slot.
  assign w_wr_ptr = r_count[PTR_W-1:0];

  assign w_count_next = i_clear ? '0 :
                        (i_wr_en ? r_count + CNT_W'(1) : r_count);

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[w_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (i_clear) begin
        r_ovf <= 1'b0;
      end else if (i_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_rd_data    = r_mem[i_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_ovf        = r_ovf;

endmodule

// File: rtl/sat_cnf_streamer.sv
// Buffers a CNF literal stream, replays it to the SAT accelerator as
// RESET/LIT/COMMIT/HOLD commands and reports the sampled SAT verdict.
module sat_cnf_streamer
  import sat_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int VAR_W   = VAR_W_DEF,
  parameter int RES_LAT = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [VAR_W-1:0] ld_var,
  input  logic             ld_neg,
  input  logic             ld_eoc,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic             ovf,
  output logic [1:0]       stateVal,
  output logic [VAR_W-1:0] varPos,
  output logic             negCtrl,
  input  logic             outSATRes,
  output logic [2:0]       dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  // Handshake: a literal transfers on a rising edge where ld_valid and
  // ld_ready are both high; ld_ready is registered and never depends on
  // ld_valid, and it is only high in LOAD with at least one free entry.

  state_t           r_state;
  logic [1:0]       r_cmd;
  logic [VAR_W-1:0] r_var;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;
  logic             r_sat;
  logic             r_ld_ready;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [WC_W-1:0]  r_wait_cnt;

  logic             w_in_load;
  logic             w_clear;
  logic             w_wr_en;
  logic             w_ovf_set;
  logic             w_start_ok;
  logic             w_at_last;
  logic [VAR_W+1:0] w_rd_data;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_ovf;

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_clear    = clear && w_in_load;
  assign w_wr_en    = ld_valid && r_ld_ready && !w_clear;
  assign w_ovf_set  = ld_valid && w_in_load && (w_count == CNT_W'(DEPTH));
  assign w_start_ok = start && w_in_load && !clear && (w_count != '0);
  assign w_at_last  = ({1'b0, r_rd_ptr} == (w_count - CNT_W'(1)));

  sat_lit_buffer #(
    .DEPTH (DEPTH),
    .VAR_W (VAR_W)
  ) u_buf (
    .i_clk        (clk),
    .i_rst_n      (resetN),
    .i_wr_en      (w_wr_en),
    .i_wr_data    ({ld_eoc, ld_neg, ld_var}),
    .i_clear      (w_clear),
    .i_ovf_set    (w_ovf_set),
    .i_rd_ptr     (r_rd_ptr),
    .o_rd_data    (w_rd_data),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_ovf        (w_ovf)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_LOAD;
      r_cmd      <= CMD_HOLD;
      r_var      <= '0;
      r_neg      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
      r_ld_ready <= 1'b1;
      r_rd_ptr   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_start_ok) begin
            r_state    <= ST_RST;
            r_busy     <= 1'b1;
            r_ld_ready <= 1'b0;
          end else begin
            r_ld_ready <= (w_count_next < CNT_W'(DEPTH));
          end
        end
        ST_RST: begin
          r_cmd    <= CMD_RESET;
          r_rd_ptr <= '0;
          r_state  <= ST_LIT;
        end
        ST_LIT: begin
          r_cmd <= CMD_LIT;
          r_var <= w_rd_data[VAR_W-1:0];
          r_neg <= w_rd_data[VAR_W];
          // The final stored literal always closes a clause, eoc or not.
          if (w_rd_data[VAR_W+1] || w_at_last) begin
            r_state <= ST_COMMIT;
          end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          end
        end
        ST_COMMIT: begin
          r_cmd <= CMD_COMMIT;
          if (w_at_last) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_state  <= ST_LIT;
          end
        end
        ST_WAIT: begin
          r_cmd <= CMD_HOLD;
          if (r_wait_cnt == WC_W'(RES_LAT - 1)) begin
            r_state <= ST_REPORT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        ST_REPORT: begin
          r_sat      <= outSATRes;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_ld_ready <= (w_count < CNT_W'(DEPTH));
          r_state    <= ST_LOAD;
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign ld_ready  = r_ld_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sat       = r_sat;
  assign ovf       = w_ovf;
  assign stateVal  = r_cmd;
  assign varPos    = r_var;
  assign negCtrl   = r_neg;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sat_cnf_streamer.sv
// Directed and randomized checks of sat_cnf_streamer against a queue-based
// model of the formula and the command stream it should produce.
module tb_sat_cnf_streamer;

  localparam int DEPTH   = 64;
  localparam int VAR_W   = 5;
  localparam int RES_LAT = 3;
  localparam int EW      = VAR_W + 3;

  localparam logic [1:0] C_RESET  = 2'b00;
  localparam logic [1:0] C_LIT    = 2'b01;
  localparam logic [1:0] C_COMMIT = 2'b10;
  localparam logic [1:0] C_HOLD   = 2'b11;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [VAR_W-1:0] ld_var = '0;
  logic             ld_neg = 1'b0;
  logic             ld_eoc = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             busy;
  logic             done;
  logic             sat;
  logic             ovf;
  logic [1:0]       stateVal;
  logic [VAR_W-1:0] varPos;
  logic             negCtrl;
  logic             outSATRes = 1'b0;
  logic [2:0]       dbg_state;

  sat_cnf_streamer #(
    .DEPTH   (DEPTH),
    .VAR_W   (VAR_W),
    .RES_LAT (RES_LAT)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_var    (ld_var),
    .ld_neg    (ld_neg),
    .ld_eoc    (ld_eoc),
    .start     (start),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .sat       (sat),
    .ovf       (ovf),
    .stateVal  (stateVal),
    .varPos    (varPos),
    .negCtrl   (negCtrl),
    .outSATRes (outSATRes),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: the formula as the host sees it, and the expected command stream
  typedef struct {
    logic [VAR_W-1:0] v;
    logic             n;
    logic             e;
  } lit_s;

  lit_s           buf_q[$];
  logic [EW-1:0]  exp_q[$];
  logic           model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic load_lit(input logic [VAR_W-1:0] v, input logic n, input logic e);
    check("ld_ready_before_load", {31'b0, ld_ready}, {31'b0, buf_q.size() < DEPTH});
    ld_valid = 1'b1;
    ld_var   = v;
    ld_neg   = n;
    ld_eoc   = e;
    step();
    ld_valid = 1'b0;
    if (buf_q.size() < DEPTH) buf_q.push_back('{v: v, n: n, e: e});
    else model_ovf = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    buf_q.delete();
    model_ovf = 1'b0;
    check("clear_ld_ready", {31'b0, ld_ready}, 32'd1);
    check("clear_ovf", {31'b0, ovf}, 32'd0);
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back({C_RESET, 1'b0, {VAR_W{1'b0}}});
    for (int i = 0; i < buf_q.size(); i++) begin
      exp_q.push_back({C_LIT, buf_q[i].n, buf_q[i].v});
      if (buf_q[i].e || i == buf_q.size() - 1)
        exp_q.push_back({C_COMMIT, 1'b0, {VAR_W{1'b0}}});
    end
    for (int i = 0; i < RES_LAT; i++) exp_q.push_back({C_HOLD, 1'b0, {VAR_W{1'b0}}});
  endtask

  // start a replay and compare every cycle against the expected stream
  task automatic replay(input logic res, input bit poke_start);
    logic [EW-1:0] e;
    bit            poked;
    poked = 1'b0;
    build_exp();
    outSATRes = res;
    start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      step();
      start = 1'b0;
      e = exp_q.pop_front();
      check("cmd", {30'b0, stateVal}, {30'b0, e[EW-1 -: 2]});
      check("busy_in_replay", {31'b0, busy}, 32'd1);
      check("no_early_done", {31'b0, done}, 32'd0);
      check("ld_ready_stalled", {31'b0, ld_ready}, 32'd0);
      if (e[EW-1 -: 2] == C_LIT) begin
        check("varPos", {27'b0, varPos}, {27'b0, e[VAR_W-1:0]});
        check("negCtrl", {31'b0, negCtrl}, {31'b0, e[VAR_W]});
      end
      if (poke_start && !poked && e[EW-1 -: 2] == C_HOLD) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    step();
    check("done_pulse", {31'b0, done}, 32'd1);
    check("sat_verdict", {31'b0, sat}, {31'b0, res});
    check("busy_fall", {31'b0, busy}, 32'd0);
    check("cmd_after_done", {30'b0, stateVal}, {30'b0, C_HOLD});
    outSATRes = ~res;
    step();
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("sat_held", {31'b0, sat}, {31'b0, res});
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("ld_ready_after", {31'b0, ld_ready}, {31'b0, buf_q.size() < DEPTH});
    check("ovf_sticky", {31'b0, ovf}, {31'b0, model_ovf});
  endtask

  task automatic start_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ign_busy", {31'b0, busy}, 32'd0);
      check("ign_done", {31'b0, done}, 32'd0);
      check("ign_cmd", {30'b0, stateVal}, {30'b0, C_HOLD});
    end
  endtask

  task automatic rand_formula();
    int  nc;
    int  nl;
    bit  drop_eoc;
    do_clear();
    nc = $urandom_range(1, 4);
    drop_eoc = ($urandom_range(0, 1) == 1);
    for (int c = 0; c < nc; c++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        load_lit(VAR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 (l == nl - 1) && !(drop_eoc && c == nc - 1));
      end
    end
  endtask

  initial begin
    step();
    step();
    check("rst_cmd", {30'b0, stateVal}, {30'b0, C_HOLD});
    check("rst_varPos", {27'b0, varPos}, 32'd0);
    check("rst_negCtrl", {31'b0, negCtrl}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sat", {31'b0, sat}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    resetN = 1'b1;
    step();

    // empty buffer: start must be ignored
    start_ignored();

    // single clause (x3), satisfiable
    load_lit(5'd3, 1'b0, 1'b1);
    replay(1'b1, 1'b0);

    // (x0 | ~x1)(x2), unsatisfiable, with a stray start during WAIT
    do_clear();
    load_lit(5'd0, 1'b0, 1'b0);
    load_lit(5'd1, 1'b1, 1'b1);
    load_lit(5'd2, 1'b0, 1'b1);
    replay(1'b0, 1'b1);
    // same buffer replays again
    replay(1'b1, 1'b0);

    // last literal without eoc still commits
    do_clear();
    load_lit(5'd7, 1'b1, 1'b1);
    load_lit(5'd9, 1'b0, 1'b0);
    load_lit(5'd31, 1'b1, 1'b0);
    replay(1'b1, 1'b0);

    // randomized formulas
    for (int it = 0; it < 8; it++) begin
      rand_formula();
      replay(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1));
    end

    // fill to DEPTH, then one extra literal overflows
    do_clear();
    for (int i = 0; i < DEPTH; i++)
      load_lit(VAR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0));
    check("full_ld_ready", {31'b0, ld_ready}, 32'd0);
    check("full_no_ovf", {31'b0, ovf}, 32'd0);
    load_lit(5'd1, 1'b0, 1'b1);
    check("ovf_set", {31'b0, ovf}, 32'd1);
    replay(1'($urandom_range(0, 1)), 1'b0);
    do_clear();
    start_ignored();

    // reset during LIT
    load_lit(5'd4, 1'b0, 1'b0);
    load_lit(5'd5, 1'b1, 1'b0);
    load_lit(5'd6, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_cmd_lit", {30'b0, stateVal}, {30'b0, C_LIT});
    resetN = 1'b0;
    #1;
    check("mid_rst_cmd", {30'b0, stateVal}, {30'b0, C_HOLD});
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    step();
    resetN = 1'b1;
    buf_q.delete();
    model_ovf = 1'b0;
    start_ignored();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_cnf_streamer.md
# sat_cnf_streamer

Formula-side driver for the SAT accelerator array. Buffers a CNF formula loaded as a literal stream, replays it as the per-cycle `stateVal`/`varPos`/`negCtrl` command stream consumed by the accelerator top, then samples the array's registered `outSATRes` and reports a single SAT/UNSAT verdict. Sits between the host/load logic and the accelerator top, in the same clock domain.

## Interface
- `DEPTH`, 64: literal buffer entries (power of two).
- `VAR_W`, 5: variable index width; matches `varPos`.
- `RES_LAT`, 3: cycles from the final clause-commit command to a valid `outSATRes`.
- `clk`  in  1  system clock, all logic on rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  load literal valid.
- `ld_ready`  out  1  buffer can accept a literal.
- `ld_var`  in  VAR_W  literal variable index.
- `ld_neg`  in  1  literal is negated.
- `ld_eoc`  in  1  literal closes its clause.
- `start`  in  1  one-cycle pulse: replay buffered formula.
- `clear`  in  1  one-cycle pulse: empty the buffer (LOAD only).
- `busy`  out  1  replay or result wait in progress.
- `done`  out  1  one-cycle pulse: `sat` valid.
- `sat`  out  1  verdict, held until next `start`.
- `ovf`  out  1  sticky: literal load attempted while full.
- `stateVal`  out  2  command to accelerator: 00 RESET, 01 LIT, 10 COMMIT, 11 HOLD.
- `varPos`  out  VAR_W  literal variable, meaningful when `stateVal`=01.
- `negCtrl`  out  1  literal polarity, meaningful when `stateVal`=01.
- `outSATRes`  in  1  registered OR of all accelerator CNF outputs.

## Operation
- States: LOAD, RST, LIT, COMMIT, WAIT, REPORT.
- Reset: state LOAD; `stateVal`=11, `varPos`=0, `negCtrl`=0, `busy`=0, `done`=0, `sat`=0, `ovf`=0, `ld_ready`=1, write pointer 0.
- LOAD: literal `{ld_eoc, ld_neg, ld_var}` written at wr_ptr on `ld_valid && ld_ready`; `ld_ready`=0 when count=DEPTH or state≠LOAD. `ld_valid` while full sets `ovf`, literal dropped. `clear` zeroes count and `ovf`. `start` with count=0 is ignored (no `done`). Last stored literal is forced to close a clause on replay even if its `ld_eoc`=0.
- RST: one cycle `stateVal`=00, rd_ptr=0, `busy`=1.
- LIT: one cycle per literal, `stateVal`=01, `varPos`/`negCtrl` from entry rd_ptr; entry with eoc → COMMIT next, else LIT with rd_ptr+1.
- COMMIT: one cycle `stateVal`=10; if rd_ptr was the last entry → WAIT, else LIT with rd_ptr+1.
- WAIT: `stateVal`=11 for RES_LAT cycles (counter), then REPORT.
- REPORT: `sat` <= `outSATRes`, `done`=1 for this cycle, `busy`=0, → LOAD. Buffer contents retained; `start` replays the same formula.
- `start`/`clear` outside LOAD ignored. Loads during replay stalled by `ld_ready`=0.
- `resetN` low mid-replay: immediate return to reset values; buffer count 0.

## Timing
- All outputs registered; command appears the cycle after the state is entered.
- `start` sampled at edge t → RESET command at t+1.
- Formula of L literals in C clauses: `done` at edge `t + 1 + L + C + RES_LAT + 1`.
- `done` and `sat` update on the same edge; `busy` falls on that edge.
- `ld_ready` deasserts combinationally-free: registered, one entry of slack not provided; full means full.

## Structure
- Package `sat_pkg`: command encodings `CMD_RESET/LIT/COMMIT/HOLD`, state enum, literal entry struct `{eoc, neg, var}`, `VAR_W` default.
- One sub-module `sat_lit_buffer`: DEPTH×(VAR_W+2) register array, write pointer/count, `ovf`, read port by rd_ptr.

## Test plan
- Single clause (x3) loaded, start → stream 00, 01/var3/neg0, 10, 11×3; `outSATRes`=1 in WAIT → `done`, `sat`=1 at cycle t+7.
- (x0 ∨ ¬x1)(x2): commands 00,01(0,0),01(1,1),10,01(2,0),10; `outSATRes`=0 → `sat`=0.
- Load DEPTH+1 literals → `ld_ready`=0 after DEPTH, `ovf`=1; `clear` → count 0, `ovf`=0.
- Last literal with `ld_eoc`=0 → COMMIT still emitted before WAIT.
- `start` with empty buffer → no `busy`, no `done`; `start` during WAIT ignored.
- `resetN` low during LIT → next cycle `stateVal`=11, `busy`=0, `ld_ready`=1, count 0.
